vec_collect: RTL and testbench



---
 rtl/vec_collect.sv | 104 ++++++++++
 tb/tb_vec_collect.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_collect.sv
// rtl/vec_collect.sv - reassembles BUS_WIDTH beats into full vectors with their popcount
// Output register is loaded straight from the assembly words plus the completing beat.
module vec_collect #(
    parameter int VECTOR_WIDTH  = 920,
    parameter int BUS_WIDTH     = 128,
    parameter int SUB_VECTOR_NO = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH,
    parameter int CNT_WIDTH     = $clog2(VECTOR_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BUS_WIDTH-1:0]    up_SubVector,
    input  logic                    up_Valid,
    input  logic [CNT_WIDTH-1:0]    up_Cnt,
    input  logic                    up_CntNew,
    input  logic                    up_Last,
    output logic                    up_Ready,
    output logic [VECTOR_WIDTH-1:0] dn_Vector,
    output logic [CNT_WIDTH-1:0]    dn_Cnt,
    output logic                    dn_Last,
    output logic                    dn_Valid,
    input  logic                    dn_Ready,
    output logic                    o_CntErr
);

    localparam int IDX_W  = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;
    localparam int ASM_W  = (SUB_VECTOR_NO - 1) * BUS_WIDTH;
    localparam int TAIL_W = VECTOR_WIDTH - ASM_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SUB_VECTOR_NO - 1);

    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [ASM_W-1:0]        asm_q, asm_d;
    logic [VECTOR_WIDTH-1:0] vec_q, vec_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    last_q, last_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;

    logic is_last_word;
    logic beat_acc;
    logic complete_acc;

    assign is_last_word = (idx_q == LAST_IDX);
    // Only the completing beat can stall, and only while the output slot stays occupied.
    assign up_Ready     = !is_last_word || !valid_q || dn_Ready;
    assign beat_acc     = up_Valid && up_Ready;
    assign complete_acc = beat_acc && is_last_word;

    always_comb begin
        idx_d   = idx_q;
        asm_d   = asm_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        valid_d = valid_q && !dn_Ready;
        err_d   = err_q;

        if (beat_acc) begin
            idx_d = is_last_word ? '0 : idx_q + 1'b1;
            for (int k = 0; k < SUB_VECTOR_NO - 1; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    asm_d[k*BUS_WIDTH +: BUS_WIDTH] = up_SubVector;
                end
            end
            if ((up_CntNew != is_last_word) ||
                (is_last_word && (32'(up_Cnt) > VECTOR_WIDTH))) begin
                err_d = 1'b1;
            end
        end

        if (complete_acc) begin
            vec_d   = {up_SubVector[TAIL_W-1:0], asm_q};
            cnt_d   = up_Cnt;
            last_d  = up_Last;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            asm_q   <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign dn_Vector = vec_q;
    assign dn_Cnt    = cnt_q;
    assign dn_Last   = last_q;
    assign dn_Valid  = valid_q;
    assign o_CntErr  = err_q;

endmodule

// File: tb/tb_vec_collect.sv
// tb/tb_vec_collect.sv - scoreboard bench for vec_collect
module tb_vec_collect;

    localparam int VW = 920;
    localparam int BW = 128;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] up_SubVector = '0;
    logic          up_Valid = 1'b0;
    logic [CW-1:0] up_Cnt = '0;
    logic          up_CntNew = 1'b0;
    logic          up_Last = 1'b0;
    logic          up_Ready;
    logic [VW-1:0] dn_Vector;
    logic [CW-1:0] dn_Cnt;
    logic          dn_Last;
    logic          dn_Valid;
    logic          dn_Ready = 1'b1;
    logic          o_CntErr;

    typedef struct {
        logic [VW-1:0] v;
        logic [CW-1:0] c;
        logic          l;
    } exp_t;

    exp_t sb[$];
    int   hs_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    vec_collect dut (
        .clk(clk), .rst(rst),
        .up_SubVector(up_SubVector), .up_Valid(up_Valid), .up_Cnt(up_Cnt),
        .up_CntNew(up_CntNew), .up_Last(up_Last), .up_Ready(up_Ready),
        .dn_Vector(dn_Vector), .dn_Cnt(dn_Cnt), .dn_Last(dn_Last),
        .dn_Valid(dn_Valid), .dn_Ready(dn_Ready), .o_CntErr(o_CntErr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [BW-1:0] pat(input int v, input int k);
        logic [7:0] b;
        b = 8'(v * 16 + k);
        return {16{b}};
    endfunction

    function automatic logic [VW-1:0] build(input int v);
        logic [8*BW-1:0] tmp;
        tmp = '0;
        for (int k = 0; k < 8; k++) tmp[k*BW +: BW] = pat(v, k);
        return tmp[VW-1:0];
    endfunction

    // Monitor: every handshake pops one expected vector.
    always @(negedge clk) begin
        if (!rst && dn_Valid && dn_Ready) begin
            exp_t e;
            hs_q.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got cnt=%0d, required no output", dn_Cnt);
            end else begin
                e = sb.pop_front();
                if (dn_Vector !== e.v || dn_Cnt !== e.c || dn_Last !== e.l) begin
                    int w;
                    w = 0;
                    for (int k = 7; k >= 0; k--)
                        if (k*BW < VW && dn_Vector[k*BW +: 8] !== e.v[k*BW +: 8]) w = k;
                    errors++;
                    $display("FAIL out_vector: got cnt=%0d last=%0b word%0d=%h, required cnt=%0d last=%0b word%0d=%h",
                             dn_Cnt, dn_Last, w, dn_Vector[w*BW +: 24], e.c, e.l, w, e.v[w*BW +: 24]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; up_Valid = 1'b0; up_CntNew = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input logic [BW-1:0] d, input logic [CW-1:0] c, input logic cn,
                        input logic l, output int waits);
        up_SubVector = d; up_Cnt = c; up_CntNew = cn; up_Last = l; up_Valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!up_Ready && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        if (!up_Ready) begin
            checks++; errors++;
            $display("FAIL beat_timeout: got up_Ready=0 for %0d cycles, required 1", waits);
        end
        @(posedge clk); #1;
        up_Valid = 1'b0; up_CntNew = 1'b0; up_Last = 1'b0;
    endtask

    // cn_beat selects which beat carries up_CntNew (7 = correct, -1 = none).
    task automatic send_vec(input int v, input logic [CW-1:0] cnt, input logic last,
                            input int cn_beat, input int nbeats, output int stalls);
        int w;
        exp_t e;
        stalls = 0;
        for (int k = 0; k < nbeats; k++) begin
            if (k == 7) begin
                e.v = build(v); e.c = cnt; e.l = last;
                sb.push_back(e);
            end
            send(pat(v, k), (k == 7) ? cnt : '0, k == cn_beat, (k == 7) ? last : 1'b0, w);
            stalls += w;
            if (cn_beat >= 0 && cn_beat < 7)
                chk("err_sticky", 64'(o_CntErr), 64'(k >= cn_beat));
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1 chk("drain_queue_size", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int st;
        exp_t e;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", 64'(dn_Valid), 64'd0);
        chk("rst_vector_zero", 64'(dn_Vector == '0), 64'd1);
        chk("rst_cnt", 64'(dn_Cnt), 64'd0);
        chk("rst_last", 64'(dn_Last), 64'd0);
        chk("rst_err", 64'(o_CntErr), 64'd0);
        chk("rst_up_ready", 64'(up_Ready), 64'd1);

        // Basic vector, beat k = {16{k}}.
        send_vec(0, 10'd100, 1'b0, 7, 8, st);
        chk("t1_valid_latency", 64'(dn_Valid), 64'd1);
        chk("t1_word0", 64'(dn_Vector[127:0] == '0), 64'd1);
        chk("t1_tail", 64'(dn_Vector[919:896]), 64'h070707);
        chk("t1_cnt", 64'(dn_Cnt), 64'd100);
        chk("t1_err", 64'(o_CntErr), 64'd0);
        wait_drain();

        // Back-to-back three vectors.
        hs_q.delete();
        begin
            int tot;
            tot = 0;
            for (int v = 1; v <= 3; v++) begin
                send_vec(v, CW'(v + 4), 1'b0, 7, 8, st);
                tot += st;
            end
            chk("b2b_stalls", 64'(tot), 64'd0);
        end
        wait_drain();
        chk("b2b_handshakes", 64'(hs_q.size()), 64'd3);
        if (hs_q.size() == 3) begin
            chk("b2b_gap01", 64'(hs_q[1] - hs_q[0]), 64'd8);
            chk("b2b_gap12", 64'(hs_q[2] - hs_q[1]), 64'd8);
        end

        // Backpressure: output full, completing beat held upstream.
        dn_Ready = 1'b0;
        send_vec(4, 10'd20, 1'b1, 7, 8, st);
        send_vec(5, 10'd21, 1'b0, 7, 7, st);
        chk("bp_beats0_6_stalls", 64'(st), 64'd0);
        e.v = build(5); e.c = 10'd21; e.l = 1'b0;
        sb.push_back(e);
        up_SubVector = pat(5, 7); up_Cnt = 10'd21; up_CntNew = 1'b1; up_Last = 1'b0; up_Valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("bp_up_ready_low", 64'(up_Ready), 64'd0);
        chk("bp_hold_valid", 64'(dn_Valid), 64'd1);
        chk("bp_hold_cnt", 64'(dn_Cnt), 64'd20);
        chk("bp_hold_last", 64'(dn_Last), 64'd1);
        @(posedge clk); #1 dn_Ready = 1'b1;
        @(negedge clk);
        chk("bp_up_ready_high", 64'(up_Ready), 64'd1);
        @(posedge clk); #1;
        up_Valid = 1'b0; up_CntNew = 1'b0;
        chk("bp_swap_valid", 64'(dn_Valid), 64'd1);
        chk("bp_swap_cnt", 64'(dn_Cnt), 64'd21);
        wait_drain();

        // up_CntNew on beat 3.
        send_vec(6, 10'd55, 1'b0, 3, 8, st);
        chk("err3_valid", 64'(dn_Valid), 64'd1);
        wait_drain();
        chk("err3_sticky_after", 64'(o_CntErr), 64'd1);

        // Count out of range on the completing beat.
        do_reset();
        chk("err921_pre", 64'(o_CntErr), 64'd0);
        send_vec(7, 10'd921, 1'b0, 7, 8, st);
        chk("err921_flag", 64'(o_CntErr), 64'd1);
        wait_drain();

        // Boundary count 920 is legal; missing up_CntNew on completing beat is not.
        do_reset();
        send_vec(11, 10'd920, 1'b0, 7, 8, st);
        chk("cnt920_ok", 64'(o_CntErr), 64'd0);
        send_vec(12, 10'd3, 1'b0, -1, 8, st);
        chk("cntnew_missing_err", 64'(o_CntErr), 64'd1);
        wait_drain();

        // Reset mid-vector with an undelivered output pending.
        do_reset();
        dn_Ready = 1'b0;
        send_vec(8, 10'd33, 1'b0, 7, 8, st);
        send_vec(9, 10'd0, 1'b0, 7, 5, st);
        chk("mid_pre_valid", 64'(dn_Valid), 64'd1);
        do_reset();
        chk("mid_valid", 64'(dn_Valid), 64'd0);
        chk("mid_vector_zero", 64'(dn_Vector == '0), 64'd1);
        chk("mid_cnt", 64'(dn_Cnt), 64'd0);
        chk("mid_last", 64'(dn_Last), 64'd0);
        chk("mid_up_ready", 64'(up_Ready), 64'd1);
        dn_Ready = 1'b1;
        send_vec(10, 10'd44, 1'b1, 7, 8, st);
        chk("mid_new_last", 64'(dn_Last), 64'd1);
        wait_drain();
        chk("mid_err", 64'(o_CntErr), 64'd0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
